wbs_burst_responder: RTL and testbench

- Wishbone pipelined slave: the responder end of the SPI-controller Wishbone master bus (cyc/stb/we/adr/tga/dat/tgc/tgd in; dat/stall/ack/err out).
- Serves burst reads and writes to an internal data memory (tgd=0) or a small register file (tgd=1).
- Used as the bus target for SPI-slave-side data, and as a checkable bus endpoint in the top-level testbench.
- Injects programmable stalls and error responses so master-side behaviour can be exercised.

---
 rtl/wb_spi_pkg.sv | 25 ++
 rtl/wbs_sp_ram.sv | 28 ++
 rtl/wbs_burst_responder.sv | 206 ++++++++++++++++++++
 tb/tb_wbs_burst_responder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_spi_pkg.sv
// Shared widths and enumerations for the SPI-side Wishbone burst responder.
package wb_spi_pkg;

  // Default bus and storage widths
  localparam int DATA_WIDTH     = 8;
  localparam int BLEN_WIDTH     = 9;
  localparam int ADDR_WIDTH     = 10;
  localparam int REG_ADDR_WIDTH = 8;
  localparam int REG_DIN_WIDTH  = 8;

  // Burst sequencing: waiting for beat 0, inside a burst, burst complete
  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DONE
  } state_t;

  // Response owed on the bus in the cycle after an accepted beat
  typedef enum logic [1:0] {
    NONE,
    ACK,
    ERR
  } resp_t;

endpackage

// File: rtl/wbs_sp_ram.sv
// Single-port synchronous RAM with registered read (one-cycle latency).
module wbs_sp_ram
  import wb_spi_pkg::*;
#(
  parameter int addr_width_g = ADDR_WIDTH,
  parameter int data_width_g = DATA_WIDTH
) (
  input  logic                    clock,
  input  logic                    en,
  input  logic                    we,
  input  logic [addr_width_g-1:0] addr,
  input  logic [data_width_g-1:0] din,
  output logic [data_width_g-1:0] dout
);

  logic [data_width_g-1:0] mem [2**addr_width_g];

  // Enabled access: optional write, read-before-write output register
  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
      end
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/wbs_burst_responder.sv
// Pipelined Wishbone slave serving burst reads/writes to a data memory
// (tgd=0) or a register file (tgd=1), with programmable stall injection
// and error responses for range overflow, master-register accesses,
// direction changes mid-burst and strobes beyond the burst length.
module wbs_burst_responder
  import wb_spi_pkg::*;
#(
  parameter int data_width_g     = DATA_WIDTH,
  parameter int blen_width_g     = BLEN_WIDTH,
  parameter int addr_width_g     = ADDR_WIDTH,
  parameter int reg_addr_width_g = REG_ADDR_WIDTH,
  parameter int reg_din_width_g  = REG_DIN_WIDTH,
  parameter int stall_every_g    = 0
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [addr_width_g-1:0] wbs_adr_i,
  input  logic [blen_width_g-1:0] wbs_tga_i,
  input  logic [data_width_g-1:0] wbs_dat_i,
  input  logic                    wbs_tgc_i,
  input  logic                    wbs_tgd_i,
  output logic [data_width_g-1:0] wbs_dat_o,
  output logic                    wbs_stall_o,
  output logic                    wbs_ack_o,
  output logic                    wbs_err_o
);

  // Range check is one bit wider than the address so base+len cannot wrap
  localparam int SUM_W = addr_width_g + 1;
  localparam logic [addr_width_g:0] MEM_LIMIT = SUM_W'((2**addr_width_g) - 1);
  localparam logic [addr_width_g:0] REG_LIMIT = SUM_W'((2**reg_addr_width_g) - 1);

  // Beat counter holds up to len+1, so it needs one bit more than tga
  localparam int CNT_W = blen_width_g + 1;
  localparam logic [blen_width_g:0] CNT_ONE = CNT_W'(1);
  localparam int STALL_DIV_INT = (stall_every_g > 0) ? stall_every_g : 1;
  localparam logic [blen_width_g:0] STALL_DIV = CNT_W'(STALL_DIV_INT);

  state_t                  state_reg, state_next;
  logic [addr_width_g-1:0] base_reg, base_next;
  logic [blen_width_g-1:0] len_reg, len_next;
  logic [blen_width_g:0]   cnt_reg, cnt_next;
  logic                    we_reg, we_next;
  logic                    tgd_reg, tgd_next;
  logic                    bad_reg, bad_next;
  resp_t                   resp_reg, resp_next;
  logic                    stall_reg, stall_next;
  logic                    rd_reg, rd_next;
  logic                    rd_tgd_reg, rd_tgd_next;
  logic [data_width_g-1:0] dat_hold_reg;

  logic                    accept;
  logic [addr_width_g:0]   start_sum;
  logic                    start_ovf;
  logic [addr_width_g-1:0] beat_addr;
  logic                    beat_live;
  logic                    beat_err;
  logic                    beat_we;
  logic                    beat_tgd;

  logic [data_width_g-1:0]    mem_q;
  logic [reg_din_width_g-1:0] reg_q;
  logic [data_width_g-1:0]    rd_data;

  assign accept    = wbs_cyc_i & wbs_stb_i & ~stall_reg;
  assign start_sum = {1'b0, wbs_adr_i} + SUM_W'(wbs_tga_i);
  assign start_ovf = start_sum > (wbs_tgd_i ? REG_LIMIT : MEM_LIMIT);

  // Burst sequencing, beat classification and next-cycle response/stall
  always_comb begin
    state_next  = state_reg;
    base_next   = base_reg;
    len_next    = len_reg;
    cnt_next    = cnt_reg;
    we_next     = we_reg;
    tgd_next    = tgd_reg;
    bad_next    = bad_reg;
    resp_next   = NONE;
    stall_next  = 1'b0;
    rd_next     = 1'b0;
    rd_tgd_next = rd_tgd_reg;
    beat_addr   = base_reg + addr_width_g'(cnt_reg);
    beat_live   = 1'b0;
    beat_err    = 1'b0;
    beat_we     = we_reg;
    beat_tgd    = tgd_reg;

    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          base_next  = wbs_adr_i;
          len_next   = wbs_tga_i;
          we_next    = wbs_we_i;
          tgd_next   = wbs_tgd_i;
          bad_next   = wbs_tgc_i | start_ovf;
          cnt_next   = CNT_ONE;
          beat_addr  = wbs_adr_i;
          beat_we    = wbs_we_i;
          beat_tgd   = wbs_tgd_i;
          beat_live  = 1'b1;
          beat_err   = wbs_tgc_i | start_ovf;
          state_next = (wbs_tga_i != '0) ? BURST : DONE;
        end
      end
      BURST: begin
        if (accept) begin
          beat_live = 1'b1;
          beat_err  = bad_reg | (wbs_we_i != we_reg);
          cnt_next  = cnt_reg + CNT_ONE;
          if (cnt_reg == {1'b0, len_reg}) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (accept) begin
          resp_next = ERR;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // cnt_next is the 1-based count of beats accepted so far in this burst
    if (beat_live) begin
      resp_next   = beat_err ? ERR : ACK;
      rd_next     = ~beat_err & ~beat_we;
      rd_tgd_next = beat_tgd;
      stall_next  = (stall_every_g != 0) &&
                    ((cnt_next % STALL_DIV) == '0) &&
                    (cnt_next <= {1'b0, len_next});
    end

    if (!wbs_cyc_i) begin
      state_next = IDLE;
    end
  end

  // State, burst context and registered bus responses
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      len_reg      <= '0;
      cnt_reg      <= '0;
      we_reg       <= 1'b0;
      tgd_reg      <= 1'b0;
      bad_reg      <= 1'b0;
      resp_reg     <= NONE;
      stall_reg    <= 1'b0;
      rd_reg       <= 1'b0;
      rd_tgd_reg   <= 1'b0;
      dat_hold_reg <= '0;
    end else begin
      state_reg    <= state_next;
      base_reg     <= base_next;
      len_reg      <= len_next;
      cnt_reg      <= cnt_next;
      we_reg       <= we_next;
      tgd_reg      <= tgd_next;
      bad_reg      <= bad_next;
      resp_reg     <= resp_next;
      stall_reg    <= stall_next;
      rd_reg       <= rd_next;
      rd_tgd_reg   <= rd_tgd_next;
      dat_hold_reg <= wbs_dat_o;
    end
  end

  // Only error-free beats touch storage; the target selects which RAM
  wbs_sp_ram #(
    .addr_width_g(addr_width_g),
    .data_width_g(data_width_g)
  ) u_data_mem (
    .clock(clock),
    .en   (beat_live & ~beat_err & ~beat_tgd),
    .we   (beat_we),
    .addr (beat_addr),
    .din  (wbs_dat_i),
    .dout (mem_q)
  );

  wbs_sp_ram #(
    .addr_width_g(reg_addr_width_g),
    .data_width_g(reg_din_width_g)
  ) u_reg_file (
    .clock(clock),
    .en   (beat_live & ~beat_err & beat_tgd),
    .we   (beat_we),
    .addr (beat_addr[reg_addr_width_g-1:0]),
    .din  (wbs_dat_i[reg_din_width_g-1:0]),
    .dout (reg_q)
  );

  // Read data shows in the ack cycle; otherwise the last value is held
  assign rd_data     = rd_tgd_reg ? data_width_g'(reg_q) : mem_q;
  assign wbs_dat_o   = rd_reg ? rd_data : dat_hold_reg;
  assign wbs_stall_o = stall_reg;
  assign wbs_ack_o   = (resp_reg == ACK);
  assign wbs_err_o   = (resp_reg == ERR);

endmodule

// File: tb/tb_wbs_burst_responder.sv
// Randomised and directed bench for wbs_burst_responder with a
// transaction-level reference model checked every cycle.
module tb_wbs_burst_responder;

  localparam int STALL_S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wbs_cyc_i = 1'b0;
  logic       wbs_stb_i = 1'b0;
  logic       wbs_we_i = 1'b0;
  logic [9:0] wbs_adr_i = '0;
  logic [8:0] wbs_tga_i = '0;
  logic [7:0] wbs_dat_i = '0;
  logic       wbs_tgc_i = 1'b0;
  logic       wbs_tgd_i = 1'b0;
  logic [7:0] wbs_dat_o;
  logic       wbs_stall_o;
  logic       wbs_ack_o;
  logic       wbs_err_o;

  int n_tests = 0;
  int n_fail = 0;
  int obs_ack = 0;
  int obs_err = 0;
  int obs_stall = 0;
  logic [7:0] rd_log[$];
  logic [7:0] drv_data[$];

  // Reference model: storage contents and current burst context
  logic [7:0] mdl_mem [1024];
  logic [7:0] mdl_reg [256];
  bit   m_active = 0;
  int   m_base = 0;
  int   m_len = 0;
  int   m_cnt = 0;
  bit   m_we = 0;
  bit   m_tgd = 0;
  bit   m_bad = 0;
  logic       exp_ack = 1'b0;
  logic       exp_err = 1'b0;
  logic       exp_stall = 1'b0;
  logic [7:0] exp_dat = '0;

  wbs_burst_responder #(
    .stall_every_g(STALL_S)
  ) dut (
    .clock      (clk),
    .rst        (rst),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_tga_i  (wbs_tga_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_tgc_i  (wbs_tgc_i),
    .wbs_tgd_i  (wbs_tgd_i),
    .wbs_dat_o  (wbs_dat_o),
    .wbs_stall_o(wbs_stall_o),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_err_o  (wbs_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model one cycle
  always @(negedge clk) begin : cmp
    logic r_ack, r_err, r_stall;
    logic [7:0] r_dat;
    bit acc;
    int a;
    if (!rst) begin
      r_ack = 1'b0; r_err = 1'b0; r_stall = 1'b0; r_dat = '0;
    end else begin
      r_ack = exp_ack; r_err = exp_err; r_stall = exp_stall; r_dat = exp_dat;
    end
    check("ack", {31'd0, wbs_ack_o}, {31'd0, r_ack});
    check("err", {31'd0, wbs_err_o}, {31'd0, r_err});
    check("stall", {31'd0, wbs_stall_o}, {31'd0, r_stall});
    check("dat", {24'd0, wbs_dat_o}, {24'd0, r_dat});
    if (wbs_ack_o) begin
      obs_ack++;
      rd_log.push_back(wbs_dat_o);
    end
    if (wbs_err_o) obs_err++;
    if (wbs_stall_o) obs_stall++;

    if (!rst) begin
      m_active = 0;
      exp_ack = 1'b0; exp_err = 1'b0; exp_stall = 1'b0; exp_dat = '0;
    end else begin
      acc = wbs_cyc_i && wbs_stb_i && !exp_stall;
      exp_ack = 1'b0; exp_err = 1'b0; exp_stall = 1'b0;
      if (acc) begin
        if (!m_active) begin
          m_active = 1;
          m_base = int'(wbs_adr_i);
          m_len = int'(wbs_tga_i);
          m_we = wbs_we_i;
          m_tgd = wbs_tgd_i;
          m_cnt = 0;
          m_bad = wbs_tgc_i || (m_base + m_len > (m_tgd ? 255 : 1023));
        end
        if (m_cnt > m_len) begin
          exp_err = 1'b1;
        end else begin
          a = m_base + m_cnt;
          if (m_bad || (wbs_we_i != m_we)) begin
            exp_err = 1'b1;
          end else begin
            exp_ack = 1'b1;
            if (m_we) begin
              if (m_tgd) mdl_reg[a] = wbs_dat_i;
              else mdl_mem[a] = wbs_dat_i;
            end else begin
              exp_dat = m_tgd ? mdl_reg[a] : mdl_mem[a];
            end
          end
          m_cnt++;
          if ((m_cnt % STALL_S == 0) && (m_cnt <= m_len)) exp_stall = 1'b1;
        end
      end
      if (!wbs_cyc_i) m_active = 0;
    end
  end

  // One burst: beat 0 carries adr/tga; strobes follow the stall handshake
  task automatic burst(input logic [9:0] adr, input logic [8:0] tga, input bit we,
                       input bit tgd, input bit tgc, input int nstb, input int abort_at,
                       input bit gaps, input bit flip);
    int sent = 0;
    int guard = 0;
    bit st;
    $display("[TB] burst adr=%h tga=%0d we=%0d tgd=%0d tgc=%0d strobes=%0d abort=%0d",
             adr, tga, we, tgd, tgc, nstb, abort_at);
    wbs_cyc_i = 1'b1;
    wbs_tgd_i = tgd;
    wbs_tgc_i = tgc;
    while ((sent < nstb) && !((abort_at >= 0) && (sent >= abort_at))) begin
      wbs_stb_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      wbs_adr_i = (sent == 0) ? adr : 10'($urandom);
      wbs_tga_i = (sent == 0) ? tga : 9'($urandom);
      wbs_we_i  = (flip && ($urandom_range(0, 5) == 0)) ? !we : we;
      wbs_dat_i = (sent < drv_data.size()) ? drv_data[sent] : 8'($urandom);
      @(negedge clk);
      st = wbs_stall_o;
      if (wbs_stb_i && !st) sent++;
      @(posedge clk);
      #1;
      guard++;
      if (guard > 8 * nstb + 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL drv_budget: got %0d beats accepted, expected %0d", sent, nstb);
        break;
      end
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a0, e0, s0;
    logic [7:0] d5, v3fe, v3ff;
    bit r_tgd, r_we, r_tgc, r_gaps, r_flip;
    int r_depth, r_tga, r_adr, r_extra, r_abort;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Fill both memories so every later read has a known value
    for (int blk = 0; blk < 2; blk++) begin
      drv_data.delete();
      for (int i = 0; i < 512; i++) drv_data.push_back(8'($urandom));
      burst(10'(blk * 512), 9'd511, 1, 0, 0, 512, -1, 0, 0);
    end
    drv_data.delete();
    for (int i = 0; i < 256; i++) drv_data.push_back(8'($urandom));
    burst(10'h000, 9'd255, 1, 1, 0, 256, -1, 0, 0);

    // Write burst then read back
    drv_data = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    a0 = obs_ack; e0 = obs_err;
    burst(10'h010, 9'd3, 1, 0, 0, 4, -1, 0, 0);
    check("t1_wr_acks", obs_ack - a0, 4);
    check("t1_wr_errs", obs_err - e0, 0);
    for (int i = 0; i < 4; i++) check("t1_model", {24'd0, mdl_mem[16 + i]}, 32'hA1 + i);
    drv_data.delete();
    rd_log.delete();
    burst(10'h010, 9'd3, 0, 0, 0, 4, -1, 0, 0);
    check("t1_rd_count", rd_log.size(), 4);
    for (int i = 0; i < 4; i++) check("t1_rd_dat", {24'd0, rd_log[i]}, 32'hA1 + i);

    // Register write/read; data memory at the same address untouched
    d5 = mdl_mem[5];
    drv_data = '{8'h5C};
    a0 = obs_ack;
    burst(10'h005, 9'd0, 1, 1, 0, 1, -1, 0, 0);
    check("t2_wr_ack", obs_ack - a0, 1);
    drv_data.delete();
    rd_log.delete();
    burst(10'h005, 9'd0, 0, 1, 0, 1, -1, 0, 0);
    check("t2_reg_rd", {24'd0, rd_log[0]}, 32'h5C);
    rd_log.delete();
    burst(10'h005, 9'd0, 0, 0, 0, 1, -1, 0, 0);
    check("t2_mem_rd", {24'd0, rd_log[0]}, {24'd0, d5});

    // Range overflow at the top of the data memory
    v3fe = mdl_mem[1022];
    v3ff = mdl_mem[1023];
    drv_data = '{8'h11, 8'h22, 8'h33};
    a0 = obs_ack; e0 = obs_err;
    burst(10'h3FE, 9'd2, 1, 0, 0, 3, -1, 0, 0);
    check("t3_ovf_errs", obs_err - e0, 3);
    check("t3_ovf_acks", obs_ack - a0, 0);
    drv_data.delete();
    rd_log.delete();
    burst(10'h3FE, 9'd1, 0, 0, 0, 2, -1, 0, 0);
    check("t3_rd_3fe", {24'd0, rd_log[0]}, {24'd0, v3fe});
    check("t3_rd_3ff", {24'd0, rd_log[1]}, {24'd0, v3ff});

    // Excess strobes, then a master-register access
    a0 = obs_ack; e0 = obs_err;
    burst(10'h020, 9'd1, 1, 0, 0, 3, -1, 0, 0);
    check("t4_excess_acks", obs_ack - a0, 2);
    check("t4_excess_errs", obs_err - e0, 1);
    a0 = obs_ack; e0 = obs_err;
    burst(10'h030, 9'd2, 1, 0, 1, 3, -1, 0, 0);
    check("t4_tgc_errs", obs_err - e0, 3);
    check("t4_tgc_acks", obs_ack - a0, 0);

    // Stall injection after beats 2 and 4
    a0 = obs_ack; s0 = obs_stall;
    burst(10'h040, 9'd4, 1, 0, 0, 5, -1, 0, 0);
    check("t5_acks", obs_ack - a0, 5);
    check("t5_stalls", obs_stall - s0, 2);

    // Abort after two beats; next burst uses its own address
    drv_data = '{8'h3C};
    burst(10'h090, 9'd0, 1, 0, 0, 1, -1, 0, 0);
    drv_data.delete();
    a0 = obs_ack; e0 = obs_err;
    burst(10'h080, 9'd7, 0, 0, 0, 8, 2, 0, 0);
    check("t6_abort_resp", (obs_ack - a0) + (obs_err - e0), 2);
    rd_log.delete();
    burst(10'h090, 9'd0, 0, 0, 0, 1, -1, 0, 0);
    check("t6_new_adr", {24'd0, rd_log[0]}, 32'h3C);

    // Reset in the middle of a burst clears outputs at once
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 10'h100; wbs_tga_i = 9'd7; wbs_tgd_i = 1'b0; wbs_tgc_i = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("t7_pre_ack", {31'd0, wbs_ack_o}, 1);
    check("t7_pre_stall", {31'd0, wbs_stall_o}, 1);
    #2 rst = 1'b0;
    #1;
    check("t7_rst_ack", {31'd0, wbs_ack_o}, 0);
    check("t7_rst_err", {31'd0, wbs_err_o}, 0);
    check("t7_rst_stall", {31'd0, wbs_stall_o}, 0);
    check("t7_rst_dat", {24'd0, wbs_dat_o}, 0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Random bursts against the model
    for (int b = 0; b < 150; b++) begin
      r_tgd = ($urandom_range(0, 2) == 0);
      r_we = $urandom_range(0, 1) != 0;
      r_tgc = ($urandom_range(0, 15) == 0);
      r_gaps = $urandom_range(0, 1) != 0;
      r_flip = ($urandom_range(0, 3) == 0);
      r_depth = r_tgd ? 256 : 1024;
      r_tga = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0) r_adr = r_depth - 1 - int'($urandom_range(0, 15));
      else if ($urandom_range(0, 9) == 0) r_adr = int'($urandom_range(0, 1023));
      else r_adr = int'($urandom_range(0, r_depth - 1));
      r_extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      r_abort = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, r_tga)) : -1;
      drv_data.delete();
      for (int i = 0; i < r_tga + 1 + r_extra; i++) drv_data.push_back(8'($urandom));
      burst(10'(r_adr), 9'(r_tga), r_we, r_tgd, r_tgc, r_tga + 1 + r_extra, r_abort, r_gaps, r_flip);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
